// File: rtl/button_debounce_multi.sv
// Multi-channel push-button debouncer with press, release and long-press pulses.
// Each channel: polarity fix, synchronizer, stable-time filter, hold-time FSM.
module button_debounce_multi #(
  parameter int unsigned         CHANNELS     = 4,
  parameter int unsigned         CLK_FREQ     = 10_000_000,
  parameter int unsigned         DEBOUNCE_HZ  = 100,
  parameter int unsigned         LONGPRESS_HZ = 1,
  parameter int unsigned         SYNC_STAGES  = 2,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_long
);

  localparam int unsigned DB_CYCLES   = CLK_FREQ / DEBOUNCE_HZ;
  localparam int unsigned LONG_CYCLES = CLK_FREQ / LONGPRESS_HZ;
  localparam int unsigned DB_W        = $clog2(DB_CYCLES + 1);
  localparam int unsigned HOLD_W      = $clog2(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  // Normalise polarity so 1 always means pressed; idle active-low pins read 0.
  logic [CHANNELS-1:0] pin_c;
  assign pin_c = btn_in ^ ACTIVE_LOW;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        db_cnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   long_q;
    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [HOLD_W-1:0]      hold_q;
    logic [HOLD_W-1:0]      hold_d;
    logic                   long_d;
    logic                   s_c;
    logic                   flip_c;
    logic                   rise_c;
    logic                   fall_c;

    assign s_c    = sync_q[SYNC_STAGES-1];
    assign flip_c = (s_c != level_q) && (db_cnt_q == DB_LAST);
    assign rise_c = flip_c & ~level_q;
    assign fall_c = flip_c & level_q;

    // Metastability synchronizer; the last stage feeds the filter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pin_c[i]};
      end
    end

    // Stable-time filter: level flips only after DB_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= rise_c;
        release_q <= fall_c;
        if (s_c != level_q) begin
          if (db_cnt_q == DB_LAST) begin
            level_q  <= ~level_q;
            db_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
          end
        end else begin
          db_cnt_q <= '0;
        end
      end
    end

    // Hold-time FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        hold_q  <= '0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        long_q  <= long_d;
      end
    end

    // Next-state logic: one long pulse per press, release always wins.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      long_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise_c) begin
            state_d = ST_PRESSED;
            hold_d  = '0;
          end
        end
        ST_PRESSED: begin
          if (fall_c) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (hold_q == HOLD_LAST) begin
            state_d = ST_HELD;
            long_d  = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_HELD: begin
          if (fall_c) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      endcase
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_long[i]    = long_q;
  end

endmodule
